// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard unit: Execute-stage forwarding, load-use and redirect stall/flush,
// and a latency-counting FSM that holds the pipeline for multi-cycle Execute ops.
module hazard_ctrl_mc #(
  parameter int unsigned REG_AW   = 3,
  parameter int unsigned LAT_W    = 4,
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned PERF_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegwriteM,
  input  logic              RegwriteW,
  input  logic [1:0]        ResultSrcE,
  input  logic              PCSrcE,
  input  logic              mc_startE,
  input  logic [LAT_W-1:0]  mc_latE,
  output logic [1:0]        Forward_A_E,
  output logic [1:0]        Forward_B_E,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              mc_busy,
  output logic              mc_done,
  output logic [PERF_W-1:0] perf_stall_cnt
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e             state_q, state_d;
  logic [LAT_W-1:0]   cnt_q, cnt_d;
  logic [PERF_W-1:0]  perf_q, perf_d;

  logic       mc_stall, lu, done_int;
  logic [1:0] fwd_a, fwd_b;

  function automatic logic reg_match(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
    return (a == b) && (!ZERO_REG || (a != '0));
  endfunction

  always_comb begin
    fwd_a = 2'b00;
    if (RegwriteM && reg_match(RdM, Rs1E))      fwd_a = 2'b10;
    else if (RegwriteW && reg_match(RdW, Rs1E)) fwd_a = 2'b01;
    fwd_b = 2'b00;
    if (RegwriteM && reg_match(RdM, Rs2E))      fwd_b = 2'b10;
    else if (RegwriteW && reg_match(RdW, Rs2E)) fwd_b = 2'b01;
  end

  assign lu = (ResultSrcE == 2'b01) && (reg_match(RdE, Rs1D) || reg_match(RdE, Rs2D));

  // cnt holds the stall cycles still owed after the current one; the op's first
  // E cycle is spent in StIdle, so an L-cycle op loads L-2.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mc_stall = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mc_startE && ((mc_latE >> 1) != '0)) begin
          mc_stall = 1'b1;
          state_d  = StBusy;
          cnt_d    = mc_latE - LAT_W'(2);
        end
      end
      StBusy: begin
        if (cnt_q != '0) begin
          mc_stall = 1'b1;
          cnt_d    = cnt_q - LAT_W'(1);
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign done_int = (state_q == StBusy) && (cnt_q == '0);

  // All combinational outputs are forced low while reset is asserted.
  always_comb begin
    Forward_A_E = rst ? fwd_a : 2'b00;
    Forward_B_E = rst ? fwd_b : 2'b00;
    StallF      = rst && (mc_stall || (lu && !PCSrcE));
    StallD      = StallF;
    StallE      = rst && mc_stall;
    FlushD      = rst && !mc_stall && PCSrcE;
    FlushE      = rst && !mc_stall && (lu || PCSrcE);
    FlushM      = rst && mc_stall;
    mc_busy     = rst && mc_stall;
    mc_done     = rst && done_int;
  end

  always_comb begin
    perf_d = perf_q;
    if (StallF && !(&perf_q)) perf_d = perf_q + PERF_W'(1);
  end

  assign perf_stall_cnt = perf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      perf_q  <= perf_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Scoreboard bench for hazard_ctrl_mc: a cycle model pushes expected outputs per cycle,
// and each scenario pops and compares them; a PERF_W=4 twin exercises counter saturation.
module tb_hazard_ctrl_mc;

  typedef logic [43:0] vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegwriteM, RegwriteW, PCSrcE, mc_startE;
  logic [1:0] ResultSrcE;
  logic [3:0] mc_latE;

  logic [1:0]  fa, fb, fa4, fb4;
  logic        sf, sd, se, fd, fe, fm, busy, done;
  logic        sf4, sd4, se4, fd4, fe4, fm4, busy4, done4;
  logic [15:0] perf;
  logic [3:0]  perf4;

  vec_t        sb_q[$];
  vec_t        obs, expv;
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned m_rem = 0, m_perf = 0, m_perf4 = 0;

  always #5 clk = ~clk;

  hazard_ctrl_mc u_dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .RegwriteM(RegwriteM), .RegwriteW(RegwriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .mc_startE(mc_startE), .mc_latE(mc_latE),
    .Forward_A_E(fa), .Forward_B_E(fb), .StallF(sf), .StallD(sd), .StallE(se),
    .FlushD(fd), .FlushE(fe), .FlushM(fm), .mc_busy(busy), .mc_done(done),
    .perf_stall_cnt(perf)
  );

  hazard_ctrl_mc #(.PERF_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .RegwriteM(RegwriteM), .RegwriteW(RegwriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .mc_startE(mc_startE), .mc_latE(mc_latE),
    .Forward_A_E(fa4), .Forward_B_E(fb4), .StallF(sf4), .StallD(sd4), .StallE(se4),
    .FlushD(fd4), .FlushE(fe4), .FlushM(fm4), .mc_busy(busy4), .mc_done(done4),
    .perf_stall_cnt(perf4)
  );

  function automatic logic mt(input logic [2:0] a, input logic [2:0] b);
    return (a == b) && (a != 3'd0);
  endfunction

  // m_rem = E-stage cycles of the current multi-cycle op still to run, including this one.
  function automatic logic m_mcs();
    if (m_rem == 0) return mc_startE && (mc_latE >= 4'd2);
    return m_rem > 1;
  endfunction

  function automatic vec_t exp_vec();
    logic [1:0]  xa, xb;
    logic        mcs, lu, xs, xfd, xfe, xdone;
    logic [11:0] c;
    if (!rst) return '0;
    xa = (RegwriteM && mt(RdM, Rs1E)) ? 2'b10 : (RegwriteW && mt(RdW, Rs1E)) ? 2'b01 : 2'b00;
    xb = (RegwriteM && mt(RdM, Rs2E)) ? 2'b10 : (RegwriteW && mt(RdW, Rs2E)) ? 2'b01 : 2'b00;
    mcs   = m_mcs();
    xdone = (m_rem == 1);
    lu    = (ResultSrcE == 2'b01) && (mt(RdE, Rs1D) || mt(RdE, Rs2D));
    xs    = mcs || (lu && !PCSrcE);
    xfd   = !mcs && PCSrcE;
    xfe   = !mcs && (lu || PCSrcE);
    c     = {xa, xb, xs, xs, mcs, xfd, xfe, mcs, mcs, xdone};
    return {c, c, m_perf[15:0], m_perf4[3:0]};
  endfunction

  function automatic vec_t obs_vec();
    return {fa, fb, sf, sd, se, fd, fe, fm, busy, done,
            fa4, fb4, sf4, sd4, se4, fd4, fe4, fm4, busy4, done4, perf, perf4};
  endfunction

  task automatic clear_inputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegwriteM, RegwriteW, PCSrcE, mc_startE} = '0;
    ResultSrcE = 2'b00;
    mc_latE    = 4'd0;
  endtask

  task automatic settle();
    sb_q.push_back(exp_vec());
    @(negedge clk);
  endtask

  task automatic tick();
    vec_t e;
    logic mcs;
    @(posedge clk);
    if (rst) begin
      e   = exp_vec();
      mcs = m_mcs();
      if (e[39] && m_perf < 65535) m_perf++;
      if (e[39] && m_perf4 < 15) m_perf4++;
      if (m_rem == 0) begin
        if (mcs) m_rem = 32'(mc_latE) - 1;
      end else begin
        m_rem--;
      end
    end
    #1;
  endtask

  task automatic model_reset();
    m_rem = 0; m_perf = 0; m_perf4 = 0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    model_reset();
    clear_inputs();
    RegwriteM = 1'b1; RdM = 3'd3; Rs1E = 3'd3;
    ResultSrcE = 2'b01; RdE = 3'd2; Rs2D = 3'd2; PCSrcE = 1'b1;
    mc_startE = 1'b1; mc_latE = 4'd4;
    for (int i = 0; i < 2; i++) begin
      settle();
      obs = obs_vec(); expv = sb_q.pop_front(); n_vec++;
      if (obs !== expv) begin n_err++; $display("FAIL reset_hold: got %h want %h", obs, expv); end
      tick();
    end
    clear_inputs();
    rst = 1'b1;
    settle();
    obs = obs_vec(); expv = sb_q.pop_front(); n_vec++;
    if (obs !== expv) begin n_err++; $display("FAIL reset_release: got %h want %h", obs, expv); end
    tick();
  endtask

  task automatic test_forwarding();
    for (int i = 0; i < 5; i++) begin
      clear_inputs();
      case (i)
        0: begin RegwriteM = 1; RdM = 3; RegwriteW = 1; RdW = 3; Rs1E = 3; Rs2E = 5; end
        1: begin RegwriteM = 0; RdM = 3; RegwriteW = 1; RdW = 3; Rs1E = 3; Rs2E = 5; end
        2: begin RegwriteM = 1; RdM = 5; RegwriteW = 1; RdW = 3; Rs1E = 3; Rs2E = 5; end
        3: begin RegwriteM = 1; RdM = 4; RegwriteW = 1; RdW = 4; Rs1E = 4; Rs2E = 4; end
        default: begin RdM = 6; RdW = 6; Rs1E = 6; Rs2E = 6; end
      endcase
      settle();
      obs = obs_vec(); expv = sb_q.pop_front(); n_vec++;
      if (obs !== expv) begin n_err++; $display("FAIL fwd[%0d]: got %h want %h", i, obs, expv); end
      tick();
    end
  endtask

  task automatic test_zero_reg();
    clear_inputs();
    RegwriteM = 1; RdM = 0; Rs1E = 0;
    RegwriteW = 1; RdW = 0; Rs2E = 0;
    ResultSrcE = 2'b01; RdE = 0; Rs1D = 0; Rs2D = 0;
    settle();
    obs = obs_vec(); expv = sb_q.pop_front(); n_vec++;
    if (obs !== expv) begin n_err++; $display("FAIL zero_reg: got %h want %h", obs, expv); end
    tick();
  endtask

  task automatic test_load_use_branch();
    for (int i = 0; i < 4; i++) begin
      clear_inputs();
      ResultSrcE = 2'b01; RdE = 3'd2; Rs2D = 3'd2;
      if (i == 1) PCSrcE = 1'b1;
      if (i == 2) begin Rs2D = 3'd0; Rs1D = 3'd2; ResultSrcE = 2'b10; end
      if (i == 3) begin Rs2D = 3'd0; Rs1D = 3'd2; end
      settle();
      obs = obs_vec(); expv = sb_q.pop_front(); n_vec++;
      if (obs !== expv) begin n_err++; $display("FAIL lu_br[%0d]: got %h want %h", i, obs, expv); end
      tick();
    end
  endtask

  task automatic test_random_hazards();
    for (int i = 0; i < 40; i++) begin
      Rs1D = 3'($urandom_range(0, 7)); Rs2D = 3'($urandom_range(0, 7));
      Rs1E = 3'($urandom_range(0, 7)); Rs2E = 3'($urandom_range(0, 7));
      RdE  = 3'($urandom_range(0, 7)); RdM  = 3'($urandom_range(0, 7));
      RdW  = 3'($urandom_range(0, 7));
      RegwriteM  = 1'($urandom_range(0, 1)); RegwriteW = 1'($urandom_range(0, 1));
      ResultSrcE = 2'($urandom_range(0, 3)); PCSrcE    = 1'($urandom_range(0, 1));
      mc_startE  = 1'b0;
      settle();
      obs = obs_vec(); expv = sb_q.pop_front(); n_vec++;
      if (obs !== expv) begin n_err++; $display("FAIL rand[%0d]: got %h want %h", i, obs, expv); end
      tick();
    end
  endtask

  task automatic test_multicycle();
    clear_inputs();
    mc_startE = 1'b1; mc_latE = 4'd4;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) mc_startE = 1'b0;
      settle();
      obs = obs_vec(); expv = sb_q.pop_front(); n_vec++;
      if (obs !== expv) begin n_err++; $display("FAIL mc4[%0d]: got %h want %h", i, obs, expv); end
      tick();
    end
  endtask

  task automatic test_edge_latencies();
    // lat 1, lat 0, lat 2, then lat 5 with a redirect and load-use pending.
    for (int op = 0; op < 4; op++) begin
      clear_inputs();
      mc_startE = 1'b1;
      mc_latE = (op == 0) ? 4'd1 : (op == 1) ? 4'd0 : (op == 2) ? 4'd2 : 4'd5;
      if (op == 3) begin PCSrcE = 1'b1; ResultSrcE = 2'b01; RdE = 3'd1; Rs1D = 3'd1; end
      for (int i = 0; i < 6; i++) begin
        if (i == 32'(mc_latE)) mc_startE = 1'b0;
        settle();
        obs = obs_vec(); expv = sb_q.pop_front(); n_vec++;
        if (obs !== expv) begin
          n_err++; $display("FAIL edge[%0d.%0d]: got %h want %h", op, i, obs, expv);
        end
        tick();
      end
    end
  endtask

  task automatic test_async_reset_mid_op();
    clear_inputs();
    mc_startE = 1'b1; mc_latE = 4'd15;
    for (int i = 0; i < 4; i++) begin
      settle();
      obs = obs_vec(); expv = sb_q.pop_front(); n_vec++;
      if (obs !== expv) begin n_err++; $display("FAIL mc15[%0d]: got %h want %h", i, obs, expv); end
      tick();
    end
    #2;
    RegwriteM = 1'b1; RdM = 3'd5; Rs2E = 3'd5; PCSrcE = 1'b1;
    rst = 1'b0;
    model_reset();
    sb_q.push_back(exp_vec());
    #1;
    obs = obs_vec(); expv = sb_q.pop_front(); n_vec++;
    if (obs !== expv) begin n_err++; $display("FAIL async_rst: got %h want %h", obs, expv); end
    tick();
    clear_inputs();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      obs = obs_vec(); expv = sb_q.pop_front(); n_vec++;
      if (obs !== expv) begin n_err++; $display("FAIL post_rst[%0d]: got %h want %h", i, obs, expv); end
      tick();
    end
  endtask

  task automatic test_perf_saturation();
    clear_inputs();
    ResultSrcE = 2'b01; RdE = 3'd2; Rs1D = 3'd2;
    for (int i = 0; i < 20; i++) begin
      settle();
      obs = obs_vec(); expv = sb_q.pop_front(); n_vec++;
      if (obs !== expv) begin n_err++; $display("FAIL perf_sat[%0d]: got %h want %h", i, obs, expv); end
      tick();
    end
    clear_inputs();
    settle();
    obs = obs_vec(); expv = sb_q.pop_front(); n_vec++;
    if (obs !== expv) begin n_err++; $display("FAIL perf_hold: got %h want %h", obs, expv); end
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_forwarding();
    test_zero_reg();
    test_load_use_branch();
    test_random_hazards();
    test_multicycle();
    test_edge_latencies();
    test_async_reset_mid_op();
    test_perf_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded 200000 time units, got timeout want finish");
    $fatal(1);
  end

endmodule
